fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end. Owns the program counter and drives the address port of the instruction memory.
- The instruction memory is a synchronous-read array: `data <= mem[addr[31:2]]` every posedge, with no enable.
- fetch_unit captures each returned word, tags it with its PC, and delivers (pc, instr) pairs to decode over a valid/ready handshake.
- Supports back-pressure from decode and a PC redirect (branch/jump) that flushes all in-flight work.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_addr  out  ADDR_W  byte address to instruction memory; equals pc register.
- mem_data  in  DATA_W  memory read data, valid the cycle after the address was presented.
- redirect_valid  in  1  one-cycle request to change PC.
- redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored (forced 0).
- out_valid  out  1  out_pc/out_instr hold a valid instruction.
- out_ready  in  1  decode accepts when out_valid & out_ready.
- out_pc  out  ADDR_W  PC of the delivered instruction.
- out_instr  out  DATA_W  delivered instruction word.

Behaviour:
- Reset (async assert, sync deassert by system):
  - pc=RESET_PC, pending=0, FIFO count=0.
  - out_valid=0, out_pc=0, out_instr=0.
  - mem_data arriving during or just after reset is discarded.
- Addressing:
  - mem_addr = pc, combinational from the pc register.
  - pc[1:0] is always 0.
  - pc increments by 4 and wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Issue:
  - A request issues in cycle C when all hold: !redirect_valid, and (count + pending <= 1, or count + pending == 2 with pop in C).
  - Pop means out_valid & out_ready.
  - On issue: pending<=1, pending_pc<=pc, pc<=pc+4.
  - Without issue: pc holds. The memory still reads every cycle; the result is ignored.
- Response:
  - In C+1, if pending=1, {pending_pc, mem_data} is written into the 2-entry output FIFO at the clock edge ending C+1.
  - pending clears unless a new issue occurs in C+1.
- Output:
  - out_valid = (count != 0). out_pc/out_instr come from the FIFO head.
  - Latency from pc on mem_addr to out_valid: 2 cycles.
  - Throughput: 1 instruction/cycle while out_ready=1.
  - Stall: while out_valid & !out_ready, out_valid/out_pc/out_instr hold stable.
  - The FIFO never overflows; the issue rule guarantees a free slot.
  - A simultaneous FIFO write and pop is legal; count is unchanged.
- Redirect (priority over all else):
  - In the cycle redirect_valid=1: a pop in the same cycle completes normally, and no issue occurs.
  - At the edge ending that cycle: FIFO flushed (count=0), pending=0 (the response due next cycle is dropped), pc<={redirect_pc[31:2],2'b00}.
  - Next cycle: out_valid=0 and mem_addr=redirect target, which issues. The first post-redirect instruction has out_valid 2 cycles after the redirect cycle.
  - Back-to-back redirects: the last one wins; each drops everything before it.
- Invariants:
  - count <= 2.
  - count + pending <= 2 after any edge.
  - out_pc values are strictly the issued sequence between redirects; no duplicates, no gaps.

Decomposition:
- Shared package fetch_pkg holds:
  - PC_INC (4).
  - Default RESET_PC.
  - FIFO_DEPTH (2).
  - fetch_pkt_t struct {pc, instr}.
- One sub-module: fetch_fifo, a 2-entry synchronous FIFO of fetch_pkt_t with push/pop/flush and count, async active-low reset.
- fetch_unit contains the pc/pending logic and the issue rule.

Test Plan:
- Bench instantiates the instruction memory with words 0..9 = A00000AA, 10000011, 20000022, ... 90000099.
- Reset release, out_ready=1:
  - mem_addr sequence 0,4,8,... one per cycle.
  - First out_valid 2 cycles after release with out_pc=0, out_instr=A00000AA.
  - Then out_pc=4/10000011, 8/20000022 on consecutive cycles.
- Back-pressure: out_ready=0 for 5 cycles after the first valid:
  - Outputs hold 0/A00000AA.
  - mem_addr stops advancing at 8 (two entries buffered, none pending).
  - On release, pcs 0,4,8,C,... with no gap or duplicate.
- Redirect:
  - Assert redirect_valid with redirect_pc=32'h14 while delivering pc=8.
  - out_valid low next cycle; out_pc=0xC/0x10 never appear.
  - 2 cycles later out_pc=14/50000055, then 18/60000066.
- Misaligned redirect_pc=32'h1F -> fetch starts at 1C, instr 70000077.
- Simultaneous redirect and pop:
  - Pending instruction accepted in the redirect cycle; no later stale output.
- Reset mid-stall: rst_n low with count=2 ->
  - out_valid=0 immediately (async).
  - After release, fetch restarts at RESET_PC with instr A00000AA.
- PC wrap: redirect to 32'hFFFF_FFFC -> next mem_addr 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared constants and packet type for the instruction-fetch
//                front end (fetch_unit and its output FIFO).
//  Contents    : PC_INC           - PC step per sequential fetch (bytes)
//                DEFAULT_RESET_PC - PC fetched first after reset
//                FIFO_DEPTH       - output FIFO entries
//                CNT_W / PTR_W    - FIFO occupancy / pointer widths
//                fetch_pkt_t      - {pc, instr} pair delivered to decode
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int          PKT_ADDR_W       = 32;
    localparam int          PKT_DATA_W       = 32;
    localparam int          PC_INC           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          FIFO_DEPTH       = 2;
    localparam int          CNT_W            = $clog2(FIFO_DEPTH + 1);
    localparam int          PTR_W            = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [PKT_ADDR_W-1:0] pc;
        logic [PKT_DATA_W-1:0] instr;
    } fetch_pkt_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_fifo
//  Description : Small synchronous FIFO of fetch_pkt_t between the memory
//                response capture and decode. Flush has priority over
//                push/pop; simultaneous push and pop keeps the count.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                i_push/i_pkt     - write one packet
//                i_pop            - retire the head packet
//                i_flush          - discard all entries
//                o_head           - head packet (zero after reset)
//                o_count          - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  fetch_pkt_t       i_pkt,
    input  logic             i_pop,
    input  logic             i_flush,
    output fetch_pkt_t       o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(FIFO_DEPTH - 1);

    fetch_pkt_t       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Storage is cleared so the head reads as zero out of reset.
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_pkt;
                r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Owns the PC, addresses a
//                synchronous-read instruction memory, tags each returned
//                word with its PC and hands {pc, instr} to decode over a
//                valid/ready handshake. A redirect flushes all in-flight work.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                mem_addr          - byte address to memory (= pc register)
//                mem_data          - read data, one cycle after mem_addr
//                redirect_valid/pc - change PC (bits [1:0] ignored)
//                out_valid/ready   - decode handshake
//                out_pc/out_instr  - delivered instruction and its PC
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr
);

    localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_reset_pc   = RESET_PC & c_align_mask;
    localparam logic [ADDR_W-1:0] c_pc_inc     = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pending;
    logic [ADDR_W-1:0] r_pending_pc;

    logic [CNT_W-1:0]  w_count;
    logic [CNT_W:0]    w_occ;
    logic              w_pop;
    logic              w_issue;
    logic              w_push;
    fetch_pkt_t        w_push_pkt;
    fetch_pkt_t        w_head;

    assign w_pop = out_valid & out_ready;

    // Buffered plus in-flight words. A new request may only go out when its
    // response is guaranteed a FIFO slot on arrival; a pop this cycle frees one.
    assign w_occ   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_pending};
    assign w_issue = !redirect_valid &&
                     ((w_occ <= (CNT_W+1)'(FIFO_DEPTH - 1)) ||
                      ((w_occ == (CNT_W+1)'(FIFO_DEPTH)) && w_pop));

    // A response landing in a redirect cycle belongs to the old path; the
    // FIFO flush discards it, so it is not pushed.
    assign w_push           = r_pending & !redirect_valid;
    assign w_push_pkt.pc    = r_pending_pc;
    assign w_push_pkt.instr = mem_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= c_reset_pc;
            r_pending    <= 1'b0;
            r_pending_pc <= '0;
        end else if (redirect_valid) begin
            r_pc      <= redirect_pc & c_align_mask;
            r_pending <= 1'b0;
        end else if (w_issue) begin
            r_pc         <= r_pc + c_pc_inc;
            r_pending    <= 1'b1;
            r_pending_pc <= r_pc;
        end else begin
            r_pending <= 1'b0;
        end
    end

    fetch_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pkt   (w_push_pkt),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign mem_addr  = r_pc;
    assign out_valid = (w_count != '0);
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit with a 16-word
//                synchronous-read instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    int checks;
    int errors;

    logic [31:0] imem [16];

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_data <= imem[mem_addr[5:2]];

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ei;
        logic [31:0] ea;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [3:0] n;
        int         first;

        checks = 0;
        errors = 0;

        for (int i = 0; i < 16; i++) begin
            n = (i == 0) ? 4'hA : 4'(i);
            imem[i] = (i < 10) ? {n, 20'h0, n, n} : (32'hE000_0000 | 32'(i));
        end

        //           rdy   rv    rpc            ev    epc            ei             ea
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_0004};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'hA000_00AA, 32'h0000_0008};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'hA000_00AA, 32'h0000_0008};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'hA000_00AA, 32'h0000_0008};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'hA000_00AA, 32'h0000_0008};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         32'hA000_00AA, 32'h0000_0008};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'hA000_00AA, 32'h0000_0008};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h1000_0011, 32'h0000_000C};
        vecs[9]  = '{1'b1, 1'b1, 32'h14,        1'b1, 32'h8,         32'h2000_0022, 32'h0000_0010};
        vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_0014};
        vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_0018};
        vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h14,        32'h5000_0055, 32'h0000_001C};
        vecs[13] = '{1'b1, 1'b1, 32'h1F,        1'b1, 32'h18,        32'h6000_0066, 32'h0000_0020};
        vecs[14] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_001C};
        vecs[15] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_0020};
        vecs[16] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h1C,        32'h7000_0077, 32'h0000_0024};
        vecs[17] = '{1'b1, 1'b1, 32'h4,         1'b1, 32'h20,        32'h8000_0088, 32'h0000_0028};
        vecs[18] = '{1'b1, 1'b1, 32'h24,        1'b0, 32'h0,         32'h0,         32'h0000_0004};
        vecs[19] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_0024};
        vecs[20] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_0028};
        vecs[21] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h24,        32'h9000_0099, 32'h0000_002C};
        vecs[22] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'hFFFF_FFFC};
        vecs[23] = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         32'h0000_0000};
        vecs[24] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hE000_000F, 32'h0000_0004};
        vecs[25] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'hA000_00AA, 32'h0000_0008};

        // ---------------- reset state ----------------
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #2;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset mem_addr",  mem_addr,       32'h0);
        chk("reset out_pc",    out_pc,         32'h0);
        chk("reset out_instr", out_instr,      32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---------------- directed vector table ----------------
        for (int i = 0; i < NV; i++) begin
            out_ready      = vecs[i].rdy;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("row%0d mem_addr", i),  mem_addr,       vecs[i].ea);
            if (vecs[i].ev) begin
                chk($sformatf("row%0d out_pc", i),    out_pc,    vecs[i].epc);
                chk($sformatf("row%0d out_instr", i), out_instr, vecs[i].ei);
            end
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // ---------------- reset during a full stall ----------------
        out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("stall out_valid", 32'(out_valid), 32'h1);
        chk("stall out_pc",    out_pc,         32'h4);
        chk("stall mem_addr",  mem_addr,       32'hC);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'h0);
        chk("async rst mem_addr",  mem_addr,       32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        first = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 0) chk("restart mem_addr", mem_addr, 32'h0);
            if (out_valid) begin
                first = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("restart latency", 32'(first), 32'd2);
        chk("restart out_pc",    out_pc,    32'h0);
        chk("restart out_instr", out_instr, 32'hA000_00AA);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("restart2 out_valid", 32'(out_valid), 32'h1);
        chk("restart2 out_pc",    out_pc,         32'h4);
        chk("restart2 out_instr", out_instr,      32'h1000_0011);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
